// File: rtl/poly_seq_pkg.sv
// Shared types and defaults for the polynomial operand sequencer.
// Holds the FSM state enum, operand index constants and parameter defaults.
package poly_seq_pkg;

    typedef enum logic [2:0] {
        S_WAIT_OP,
        S_GO_HIGH,
        S_GO_LOW,
        S_COMPUTE,
        S_RESULT
    } state_t;

    localparam logic [1:0] OP_A = 2'd0;
    localparam logic [1:0] OP_B = 2'd1;
    localparam logic [1:0] OP_C = 2'd2;
    localparam logic [1:0] OP_X = 2'd3;

    localparam int DEF_DATA_W         = 8;
    localparam int DEF_GO_HIGH        = 2;
    localparam int DEF_GO_LOW         = 2;
    localparam int DEF_COMPUTE_CYCLES = 7;

    // Width of the shared phase timer; wide enough for any sane pacing.
    localparam int TMR_W = 16;

    // Timer load value for a phase lasting n cycles.
    function automatic logic [TMR_W-1:0] tmr_load(input int n);
        return TMR_W'(n - 1);
    endfunction

endpackage

// File: rtl/poly_seq_timer.sv
// Loadable down-counter with a zero flag, shared by all timed FSM phases.
// Ports: clk, resetn (sync, active-low), i_load, i_load_val, o_zero.
module poly_seq_timer
    import poly_seq_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load wins over decrement; the counter parks at zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/poly_operand_sequencer.sv
// Feeds A, B, C, X to the polynomial evaluator with Go pacing and
// returns the captured evaluator result over a valid/ready stream.
//
// Ports:
//   clk, resetn              clock, sync active-low reset (shared with evaluator)
//   in_valid/in_ready/in_data    operand stream (A, B, C, X order)
//   eval_data, eval_go       evaluator DataIn / Go
//   eval_result              evaluator DataResult
//   out_valid/out_ready/out_data result stream
//   busy                     low only when idle waiting for operand A
//   eval_count               completed evaluations
//
// Optional feature: define POLY_SEQ_EVAL_COUNT_EN to enable the 16-bit
// evaluation counter; otherwise eval_count is tied to zero.
module poly_operand_sequencer
    import poly_seq_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int GO_HIGH        = DEF_GO_HIGH,
    parameter int GO_LOW         = DEF_GO_LOW,
    parameter int COMPUTE_CYCLES = DEF_COMPUTE_CYCLES
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] eval_data,
    output logic              eval_go,
    input  logic [DATA_W-1:0] eval_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [15:0]       eval_count
);

    state_t            r_state;
    logic [1:0]        r_idx;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_out_data;
    logic              r_go;
    logic              r_out_valid;
    logic              r_in_ready;

    logic              w_in_fire;
    logic              w_tmr_zero;
    logic              w_tmr_load;
    logic [TMR_W-1:0]  w_tmr_val;

    assign w_in_fire = in_valid && r_in_ready;

    // Timer reloads at each phase entry; the value is the phase length - 1.
    // The compute phase already includes X's go-low cycles.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        unique case (r_state)
            S_WAIT_OP: begin
                if (w_in_fire) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = tmr_load(GO_HIGH);
                end
            end
            S_GO_HIGH: begin
                if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = tmr_load(GO_LOW);
                end
            end
            S_GO_LOW: begin
                if (w_tmr_zero && r_idx == OP_X) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = tmr_load(COMPUTE_CYCLES - GO_LOW);
                end
            end
            default: begin
            end
        endcase
    end

    poly_seq_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .i_load    (w_tmr_load),
        .i_load_val(w_tmr_val),
        .o_zero    (w_tmr_zero)
    );

    // Outputs are registered alongside the state so they change
    // exactly on the edge that enters each state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_WAIT_OP;
            r_idx       <= OP_A;
            r_hold      <= '0;
            r_out_data  <= '0;
            r_go        <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            unique case (r_state)
                S_WAIT_OP: begin
                    if (w_in_fire) begin
                        r_hold     <= in_data;
                        r_in_ready <= 1'b0;
                        r_go       <= 1'b1;
                        r_state    <= S_GO_HIGH;
                    end
                end
                S_GO_HIGH: begin
                    if (w_tmr_zero) begin
                        r_go    <= 1'b0;
                        r_state <= S_GO_LOW;
                    end
                end
                S_GO_LOW: begin
                    if (w_tmr_zero) begin
                        if (r_idx == OP_X) begin
                            r_state <= S_COMPUTE;
                        end else begin
                            r_idx      <= r_idx + 2'd1;
                            r_in_ready <= 1'b1;
                            r_state    <= S_WAIT_OP;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (w_tmr_zero) begin
                        r_out_data  <= eval_result;
                        r_out_valid <= 1'b1;
                        r_state     <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (out_ready) begin
                        r_idx       <= OP_A;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_WAIT_OP;
                    end
                end
                default: begin
                    r_state <= S_WAIT_OP;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign eval_data = r_hold;
    assign eval_go   = r_go;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = !(r_state == S_WAIT_OP && r_idx == OP_A);

`ifdef POLY_SEQ_EVAL_COUNT_EN
    logic [15:0] r_eval_count;
    logic        w_out_fire;

    assign w_out_fire = r_out_valid && out_ready;

    // Wraps naturally from 0xFFFF to 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_eval_count <= '0;
        end else if (w_out_fire) begin
            r_eval_count <= r_eval_count + 16'd1;
        end
    end

    assign eval_count = r_eval_count;
`else
    assign eval_count = '0;
`endif

endmodule

// File: tb/tb_poly_operand_sequencer.sv
// Directed testbench for poly_operand_sequencer with a behavioural
// evaluator model that latches operands on Go rising edges.
module tb_poly_operand_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic [7:0] eval_data;
    logic       eval_go;
    logic [7:0] eval_result;
    logic       out_valid;
    logic [7:0] out_data;
    logic       busy;
    logic [15:0] eval_count;

    int checks = 0;
    int failures = 0;
    int exp_evals = 0;

    always #5 clk = ~clk;

    poly_operand_sequencer dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .eval_data  (eval_data),
        .eval_go    (eval_go),
        .eval_result(eval_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .eval_count (eval_count)
    );

    // Evaluator model: takes each operand on a Go rising edge,
    // result only meaningful once all four have been loaded.
    logic [7:0]  m_ops [4];
    logic [2:0]  m_cnt;
    logic        m_prev;
    logic [31:0] m_full;

    always @(posedge clk) begin
        if (!resetn) begin
            m_cnt  <= 3'd0;
            m_prev <= 1'b0;
        end else begin
            m_prev <= eval_go;
            if (eval_go && !m_prev) begin
                if (m_cnt == 3'd4) begin
                    m_ops[0] <= eval_data;
                    m_cnt    <= 3'd1;
                end else begin
                    m_ops[m_cnt[1:0]] <= eval_data;
                    m_cnt             <= m_cnt + 3'd1;
                end
            end
        end
    end

    assign m_full = 32'(m_ops[0]) * 32'(m_ops[3]) * 32'(m_ops[3])
                  + 32'(m_ops[1]) * 32'(m_ops[3]) + 32'(m_ops[2]);
    assign eval_result = (m_cnt == 3'd4) ? m_full[7:0] : 8'hEE;

    function automatic logic [15:0] exp_count();
`ifdef POLY_SEQ_EVAL_COUNT_EN
        return 16'(exp_evals);
`else
        return 16'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand; optionally verify the Go pacing that follows.
    task automatic send_op(input logic [7:0] d, input bit chk,
                           input bit last);
        bit acc;
        logic exp_go;
        logic exp_rdy;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        for (int k = 0; k < 200 && !acc; k++) begin
            if (in_ready === 1'b1) acc = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL accept op=%0d in_ready=%b required=1", d, in_ready);
        end
        if (chk) begin
            checks++;
            if (eval_data !== d) begin
                failures++;
                $display("FAIL eval_data got=%0d exp=%0d", eval_data, d);
            end
            for (int c = 0; c < 4; c++) begin
                exp_go = (c < 2);
                checks++;
                if (eval_go !== exp_go) begin
                    failures++;
                    $display("FAIL go_pace op=%0d cyc=%0d got=%b exp=%b",
                             d, c, eval_go, exp_go);
                end
                tick();
            end
            exp_rdy = last ? 1'b0 : 1'b1;
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL in_ready_after op=%0d got=%b exp=%b",
                         d, in_ready, exp_rdy);
            end
        end
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] x);
        send_op(a, 1'b0, 1'b0);
        send_op(b, 1'b0, 1'b0);
        send_op(c, 1'b0, 1'b0);
        send_op(x, 1'b0, 1'b1);
    endtask

    // Wait for a result with out_ready high and complete the handshake.
    task automatic get_result(input logic [7:0] exp, output int lat);
        lat = 0;
        out_ready = 1'b1;
        while (out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL out_valid_timeout got=%b exp=1", out_valid);
        end
        checks++;
        if (out_data !== exp) begin
            failures++;
            $display("FAIL out_data got=%0d exp=%0d", out_data, exp);
        end
        tick();
        exp_evals++;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL handshake out_valid=%b in_ready=%b exp 0/1",
                     out_valid, in_ready);
        end
        checks++;
        if (eval_count !== exp_count()) begin
            failures++;
            $display("FAIL eval_count got=%0d exp=%0d", eval_count,
                     exp_count());
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (in_ready !== 1'b1 || eval_go !== 1'b0 || out_valid !== 1'b0
                || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_ctl p=%0d rdy=%b go=%b ov=%b busy=%b exp 1/0/0/0",
                         p, in_ready, eval_go, out_valid, busy);
            end
            checks++;
            if (eval_data !== 8'd0 || out_data !== 8'd0 || eval_count !== 16'd0) begin
                failures++;
                $display("FAIL reset_data p=%0d ed=%0d od=%0d cnt=%0d exp 0",
                         p, eval_data, out_data, eval_count);
            end
            resetn = 1'b1;
            if (p == 0) tick();
        end
    endtask

    task automatic test_basic();
        int lat;
        send_op(8'd1, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_mid got=%b exp=1", busy);
        end
        send_op(8'd2, 1'b1, 1'b0);
        send_op(8'd3, 1'b1, 1'b0);
        send_op(8'd4, 1'b1, 1'b1);
        get_result(8'd27, lat);
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL latency got=%0d exp=5", lat);
        end
    endtask

    task automatic test_wrap();
        int lat;
        send4(8'd5, 8'd3, 8'd7, 8'd10);
        get_result(8'd25, lat);
    endtask

    task automatic test_backpressure();
        int lat;
        int w;
        send4(8'd1, 8'd2, 8'd3, 8'd4);
        out_ready = 1'b0;
        w = 0;
        while (out_valid !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        in_valid = 1'b1;
        in_data = 8'd1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'd27 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold c=%0d ov=%b od=%0d rdy=%b exp 1/27/0",
                         c, out_valid, out_data, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_evals++;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release ov=%b rdy=%b busy=%b exp 0/1/0",
                     out_valid, in_ready, busy);
        end
        send_op(8'd1, 1'b1, 1'b0);
        send_op(8'd2, 1'b0, 1'b0);
        send_op(8'd3, 1'b0, 1'b0);
        send_op(8'd4, 1'b0, 1'b1);
        get_result(8'd27, lat);
    endtask

    task automatic test_bubbles();
        int lat;
        logic [7:0] ops [4];
        ops[0] = 8'd1;
        ops[1] = 8'd2;
        ops[2] = 8'd3;
        ops[3] = 8'd4;
        for (int i = 0; i < 4; i++) begin
            send_op(ops[i], 1'b1, i == 3);
            if (i < 3) begin
                for (int g = 0; g < 5; g++) begin
                    checks++;
                    if (eval_go !== 1'b0 || in_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL bubble i=%0d g=%0d go=%b rdy=%b exp 0/1",
                                 i, g, eval_go, in_ready);
                    end
                    tick();
                end
            end
        end
        get_result(8'd27, lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        send_op(8'd5, 1'b0, 1'b0);
        send_op(8'd6, 1'b0, 1'b0);
        checks++;
        if (eval_go !== 1'b1) begin
            failures++;
            $display("FAIL mid_go got=%b exp=1", eval_go);
        end
        resetn = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || eval_go !== 1'b0 || busy !== 1'b0
            || eval_data !== 8'd0 || eval_count !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset rdy=%b go=%b busy=%b ed=%0d cnt=%0d exp 1/0/0/0/0",
                     in_ready, eval_go, busy, eval_data, eval_count);
        end
        resetn = 1'b1;
        exp_evals = 0;
        tick();
        send4(8'd0, 8'd0, 8'd9, 8'd0);
        get_result(8'd9, lat);
    endtask

    task automatic test_counter();
        int lat;
        send4(8'd2, 8'd0, 8'd0, 8'd3);
        get_result(8'd18, lat);
        send4(8'd0, 8'd1, 8'd1, 8'd255);
        get_result(8'd0, lat);
        checks++;
`ifdef POLY_SEQ_EVAL_COUNT_EN
        if (eval_count !== 16'd3) begin
            failures++;
            $display("FAIL count_final got=%0d exp=3", eval_count);
        end
`else
        if (eval_count !== 16'd0) begin
            failures++;
            $display("FAIL count_final got=%0d exp=0", eval_count);
        end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
